uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver that feeds the UART's `rx_byte` path: recovers 8N1 frames from the asynchronous `serial_rx` pin and presents each byte on a valid/ready interface.
- Sits between the board pin and the byte consumer, alongside the existing transmitter and sharing its clock and baud settings.
- Samples at mid-bit using a bit-period counter.
- Detects false starts, framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit (1 MHz / 9600 baud); must be >= 4.
- SYNC_STAGES, 2, flops in the `serial_rx` synchronizer; must be >= 2.

Ports:
- clock  input  1  system clock (1 MHz nominal)
- reset_n  input  1  asynchronous, active-low reset
- serial_rx  input  1  asynchronous serial line; idle high
- rx_byte  output  8  last received byte; LSB received first
- rx_valid  output  1  rx_byte holds an unconsumed byte
- rx_ready  input  1  consumer accepts rx_byte this cycle when rx_valid=1
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: new byte overwrote an unconsumed byte

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (reset_n). All state clears immediately on reset_n=0.
- Reset values:
  - synchronizer flops = 1; state = IDLE; counters = 0; shift register = 0.
  - rx_byte = 8'h00; rx_valid = 0; frame_error = 0; overrun = 0.
- Synchronizer: SYNC_STAGES flops. The FSM sees only the synced signal `rx_s`.
- Constants:
  - HALF = CLKS_PER_BIT/2 (integer divide).
  - bit counter width = $clog2(CLKS_PER_BIT); bit index 3 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s=0 -> START, counter=0.
  - START: counter increments each cycle.
    - At counter==HALF-1: if rx_s=1 -> IDLE (glitch, no outputs). Else -> DATA, counter=0, bit index=0.
  - DATA: counter increments.
    - At counter==CLKS_PER_BIT-1: shift = {rx_s, shift[7:1]}, counter=0, bit index+1.
    - After 8th sample -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1:
    - rx_s=1 -> commit byte, -> IDLE.
    - rx_s=0 -> frame_error=1 for one cycle, byte discarded, -> BREAK.
  - BREAK: stay until rx_s=1, then -> IDLE. Prevents a held-low line from generating repeated frames.
- Commit (registered, visible the cycle after the stop sample):
  - rx_byte <= shift; rx_valid <= 1.
  - If rx_valid=1 and rx_ready=0 at the commit edge: overrun pulses 1 cycle and rx_byte is overwritten with the new byte. rx_valid stays 1.
- Handshake:
  - rx_valid && rx_ready at an edge clears rx_valid, unless a commit occurs at the same edge.
  - Commit wins: new byte loaded, rx_valid stays 1, no overrun.
  - rx_byte is stable while rx_valid=1 and no commit occurs.
- Latency: from the first cycle rx_s=0 to rx_valid=1 is HALF + 9*CLKS_PER_BIT + 1 cycles, plus SYNC_STAGES from the pin.
- Back-to-back frames:
  - The FSM returns to IDLE at the mid-stop sample.
  - A start edge arriving half a bit later is accepted.
- Reset mid-frame: partial byte dropped, no pulses; after release, waits in IDLE for a falling edge.

Decomposition:
- Package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP, BREAK).
  - CLOCK_HZ = 1_000_000 and BAUD_HZ = 9_600.
  - derived CLKS_PER_BIT.
  - Shared with the transmitter.
- Sub-module uart_sync: parameterized SYNC_STAGES, reset value 1. Reusable for other async inputs.

Test Plan:
All scenarios use CLKS_PER_BIT=8, rx_ready tied 1 unless stated, and drive frames at the exact bit period.
1. Frame 0x41 (start, 1,0,0,0,0,0,1,0, stop) -> rx_valid=1 with rx_byte=8'h41 exactly HALF+9*8+1+SYNC_STAGES cycles after the falling edge; no error pulses.
2. Low glitch of 2 cycles on idle line -> FSM returns to IDLE; rx_valid, frame_error and overrun stay 0.
3. Frame 0xA5 with stop bit low, line returned high 20 cycles later -> frame_error pulses once; rx_valid stays 0; next frame 0x3C is received correctly.
4. rx_ready=0, frames 0x11 then 0x22 -> after the second: overrun pulses once, rx_byte=8'h22, rx_valid=1; raising rx_ready clears rx_valid next edge.
5. rx_ready asserted on exactly the commit edge of the second of two back-to-back frames (0x55, 0xAA) -> rx_byte=8'hAA, rx_valid stays 1, overrun=0.
6. reset_n pulsed low during DATA bit 4 of frame 0xFF -> outputs return to reset values immediately; a subsequent frame 0x0F yields rx_byte=8'h0F.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   CLOCK_HZ / BAUD_HZ : nominal system clock and line rate
//   CLKS_PER_BIT       : derived bit period in system clocks
//   rx_state_t         : receiver FSM state encoding
package uart_pkg;

  localparam int CLOCK_HZ     = 1_000_000;
  localparam int BAUD_HZ      = 9_600;
  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_HZ;  // 104 at 1 MHz / 9600

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous single-bit input.
// Flops reset to 1 so an idle-high line never looks active out of reset.
//   clock   : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronized output (SYNC_STAGES clocks of latency)
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) sync_reg[gi] <= 1'b1;
          else          sync_reg[gi] <= d;
        end
      end else begin : g_chain
        always_ff @(posedge clock or negedge reset_n) begin
          if (!reset_n) sync_reg[gi] <= 1'b1;
          else          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready byte output.
// Samples each bit at mid-period using a bit-period counter; rejects
// false starts, flags framing errors and overruns.
//   clock       : system clock
//   reset_n     : asynchronous active-low reset
//   serial_rx   : asynchronous serial line, idle high
//   rx_byte     : last received byte (LSB first on the line)
//   rx_valid    : rx_byte holds an unconsumed byte
//   rx_ready    : consumer takes rx_byte this cycle when rx_valid=1
//   frame_error : one-cycle pulse, stop bit sampled low
//   overrun     : one-cycle pulse, unconsumed byte was overwritten
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_error,
  output logic       overrun
);
  import uart_pkg::*;

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  logic          rx_s;
  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          commit;
  logic          stop_err;

  logic [7:0]    rx_byte_reg;
  logic          rx_valid_reg;
  logic          frame_error_reg;
  logic          overrun_reg;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (serial_rx),
    .q       (rx_s)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    commit       = 1'b0;
    stop_err     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high here was a glitch.
        if (cnt_reg == CW'(HALF - 1)) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            cnt_next     = '0;
            bit_idx_next = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
          shift_next   = {rx_s, shift_reg[7:1]};
          cnt_next     = '0;
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a following start.
        if (cnt_reg == CW'(CLKS_PER_BIT - 1)) begin
          cnt_next = '0;
          if (rx_s) begin
            commit     = 1'b1;
            state_next = IDLE;
          end else begin
            stop_err   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BREAK: begin
        // A line held low must go high before another frame is accepted.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A commit on the same edge as a consumer accept keeps rx_valid set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte_reg     <= 8'h00;
      rx_valid_reg    <= 1'b0;
      frame_error_reg <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      frame_error_reg <= stop_err;
      overrun_reg     <= 1'b0;
      if (commit) begin
        rx_byte_reg  <= shift_reg;
        rx_valid_reg <= 1'b1;
        overrun_reg  <= rx_valid_reg & ~rx_ready;
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_byte     = rx_byte_reg;
  assign rx_valid    = rx_valid_reg;
  assign frame_error = frame_error_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clock;
  logic       reset_n;
  logic       serial_rx;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_error;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int valid_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .serial_rx   (serial_rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid) begin
      valid_cnt++;
      last_byte = rx_byte;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // All drive tasks are entered and left just after a rising edge.
  task automatic send_bit(input logic b);
    serial_rx = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    $display("frame 0x%h stop=%0b driven", data, stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    serial_rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected %h", rx_byte, 8'h00); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b expected 0", frame_error); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b expected 0", overrun); end
    reset_n = 1'b1;
    idle(6);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", rx_valid); end
  endtask

  task automatic test_basic;
    int lat;
    int fe0, ov0;
    logic [7:0] got;
    lat = 0;
    got = 8'h00;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'h41, 1'b1);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(posedge clock);
          #1;
          if (rx_valid) begin
            lat = i;
            got = rx_byte;
            break;
          end
        end
      end
    join
    idle(8);
    n_checks++; if (lat != 4 + 9*CPB + 1 + 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, 4 + 9*CPB + 1 + 2); end
    n_checks++; if (got !== 8'h41) begin n_fail++; $display("FAIL basic_byte: got %h expected %h", got, 8'h41); end
    n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL basic_fe: got %0d pulses expected 0", fe_cnt - fe0); end
    n_checks++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL basic_ov: got %0d pulses expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch;
    int fe0, ov0, v0;
    fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cnt;
    serial_rx = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    idle(30);
    $display("glitch of 2 cycles driven");
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", valid_cnt - v0); end
    n_checks++; if (fe_cnt != fe0) begin n_fail++; $display("FAIL glitch_fe: got %0d pulses expected 0", fe_cnt - fe0); end
    n_checks++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL glitch_ov: got %0d pulses expected 0", ov_cnt - ov0); end
    send_frame(8'h96, 1'b1);
    idle(10);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (last_byte !== 8'h96) begin n_fail++; $display("FAIL glitch_next_byte: got %h expected %h", last_byte, 8'h96); end
  endtask

  task automatic test_frame_error;
    int fe0, v0;
    fe0 = fe_cnt; v0 = valid_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    idle(20);
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL ferr_valid: got %0d valid cycles expected 0", valid_cnt - v0); end
    send_frame(8'h3C, 1'b1);
    idle(10);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL ferr_next_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (last_byte !== 8'h3C) begin n_fail++; $display("FAIL ferr_next_byte: got %h expected %h", last_byte, 8'h3C); end
    n_checks++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_total: got %0d expected 1", fe_cnt - fe0); end
  endtask

  task automatic test_overrun;
    int ov0;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(16);
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b expected 1", rx_valid); end
    n_checks++; if (rx_byte !== 8'h11) begin n_fail++; $display("FAIL ovr_first_byte: got %h expected %h", rx_byte, 8'h11); end
    n_checks++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL ovr_first_ov: got %0d expected 0", ov_cnt - ov0); end
    send_frame(8'h22, 1'b1);
    idle(16);
    n_checks++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - ov0); end
    n_checks++; if (rx_byte !== 8'h22) begin n_fail++; $display("FAIL ovr_byte: got %h expected %h", rx_byte, 8'h22); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
    rx_ready = 1'b1;
    @(posedge clock);
    #1;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back;
    int ov0;
    ov0 = ov_cnt;
    rx_ready = 1'b0;
    fork
      begin
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
      end
      begin
        // Second commit edge is 80 + 79 edges after the first start.
        repeat (2*10*CPB - 2) @(posedge clock);
        #1;
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rx_byte !== 8'h55) begin n_fail++; $display("FAIL b2b_first_byte: got %h expected %h", rx_byte, 8'h55); end
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        n_checks++; if (rx_byte !== 8'hAA) begin n_fail++; $display("FAIL b2b_byte: got %h expected %h", rx_byte, 8'hAA); end
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_ov: got %b expected 0", overrun); end
        @(posedge clock);
        #1;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got %b expected 0", rx_valid); end
      end
    join
    idle(8);
    n_checks++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL b2b_ov_total: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, fe0, ov0;
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(8);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5*CPB + 4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_mid_byte: got %h expected %h", rx_byte, 8'h00); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", rx_valid); end
        n_checks++; if (frame_error !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses: got fe=%b ov=%b expected 0 0", frame_error, overrun); end
        repeat (2) @(posedge clock);
        #3;
        rx_ready = 1'b1;
        reset_n = 1'b1;
      end
    join
    v0 = valid_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    idle(20);
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL rst_mid_partial: got %0d valid cycles expected 0", valid_cnt - v0); end
    send_frame(8'h0F, 1'b1);
    idle(10);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL rst_next_count: got %0d expected 1", valid_cnt - v0); end
    n_checks++; if (last_byte !== 8'h0F) begin n_fail++; $display("FAIL rst_next_byte: got %h expected %h", last_byte, 8'h0F); end
    n_checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin n_fail++; $display("FAIL rst_next_pulses: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
  endtask

  initial begin
    serial_rx = 1'b1;
    rx_ready  = 1'b1;
    reset_n   = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
